instruction_sequencer: RTL and testbench

- Program sequencer and instruction decoder for the 4-bit computational unit.
- Holds the program counter (PC) and drives the 8-bit program memory address.
- Latches the returned byte into a 2-stage fetch/execute pipeline and decodes the executing instruction into the unit's control inputs: source_sel, reg_en, i_sel, x_sel, y_sel, nibble_ir.
- Resolves jumps against r_eq_0 and runs under a run/halt state machine.

---
 rtl/seq_pkg.sv | 50 +++++
 rtl/instruction_sequencer_if.sv | 31 +++
 rtl/instruction_decoder.sv | 53 +++++
 rtl/instruction_sequencer.sv | 91 +++++++++
 tb/tb_instruction_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared encodings for the instruction sequencer and its decoder.
package seq_pkg;

  localparam int unsigned PC_W = 8;
  localparam int unsigned IR_W = 8;
  localparam int unsigned EN_W = 9;
  localparam int unsigned SRC_W = 4;

  localparam logic [IR_W-1:0] NOP_IR = 8'hC8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Opcode prefixes (LOAD is ir[7]==0)
  localparam logic       OP_LOAD = 1'b0;
  localparam logic [1:0] OP_MOVE = 2'b10;
  localparam logic [2:0] OP_ALU  = 3'b110;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_JNZ  = 4'hF;

  // reg_en bit indices
  localparam int unsigned EN_X0   = 0;
  localparam int unsigned EN_X1   = 1;
  localparam int unsigned EN_Y0   = 2;
  localparam int unsigned EN_Y1   = 3;
  localparam int unsigned EN_R    = 4;
  localparam int unsigned EN_M    = 5;
  localparam int unsigned EN_I    = 6;
  localparam int unsigned EN_DM   = 7;
  localparam int unsigned EN_OREG = 8;

  // data_bus source codes; 0..7 are x0..dm in dst-code order
  localparam logic [SRC_W-1:0] SRC_NIBBLE = 4'd8;
  localparam logic [SRC_W-1:0] SRC_IPINS  = 4'd9;
  localparam logic [2:0]       DST_I      = 3'd6;
  localparam logic [2:0]       DST_OREG   = 3'd4;

  // Map a 3-bit destination code to its one-hot register enable
  function automatic logic [EN_W-1:0] dst_enable(input logic [2:0] d);
    logic [EN_W-1:0] en;
    en = '0;
    if (d == DST_OREG) en[EN_OREG] = 1'b1;
    else               en[d]       = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Program-memory and control-output bundle of the sequencer.
interface instruction_sequencer_if;
  import seq_pkg::*;

  logic                  run;
  logic [IR_W-1:0]       pm_data;
  logic                  r_eq_0;
  logic [PC_W-1:0]       pm_addr;
  logic [PC_W-1:0]       pc;
  logic [IR_W-1:0]       ir;
  logic                  ir_valid;
  logic [1:0]            state;
  logic [3:0]            nibble_ir;
  logic [SRC_W-1:0]      source_sel;
  logic [EN_W-1:0]       reg_en;
  logic                  i_sel;
  logic                  x_sel;
  logic                  y_sel;

  modport master (
    input  run, pm_data, r_eq_0,
    output pm_addr, pc, ir, ir_valid, state,
           nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel
  );

  modport slave (
    output run, pm_data, r_eq_0,
    input  pm_addr, pc, ir, ir_valid, state,
           nibble_ir, source_sel, reg_en, i_sel, x_sel, y_sel
  );
endinterface

// File: rtl/instruction_decoder.sv
// Combinational decode of the executing instruction into control outputs.
module instruction_decoder
  import seq_pkg::*;
(
  input  logic [IR_W-1:0]  ir,
  input  logic             ir_valid,
  input  logic             r_eq_0,
  output logic [SRC_W-1:0] source_sel,
  output logic [EN_W-1:0]  reg_en,
  output logic             i_sel,
  output logic             x_sel,
  output logic             y_sel,
  output logic [3:0]       nibble_ir,
  output logic             jump_taken,
  output logic [PC_W-1:0]  jump_target
);

  assign jump_target = PC_W'({ir[3:0], 4'h0});

  // Everything is held at zero while ir is not valid
  always_comb begin
    source_sel = '0;
    reg_en     = '0;
    i_sel      = 1'b0;
    x_sel      = 1'b0;
    y_sel      = 1'b0;
    nibble_ir  = '0;
    jump_taken = 1'b0;
    if (ir_valid) begin
      nibble_ir = ir[3:0];
      if (ir[7] == OP_LOAD) begin
        source_sel = SRC_NIBBLE;
        reg_en     = dst_enable(ir[6:4]);
      end else if (ir[7:6] == OP_MOVE) begin
        reg_en     = dst_enable(ir[5:3]);
        source_sel = SRC_W'(ir[2:0]);
        if (ir[2:0] == ir[5:3]) begin
          if (ir[5:3] == DST_I) i_sel      = 1'b1;
          else                  source_sel = SRC_IPINS;
        end
      end else if (ir[7:5] == OP_ALU) begin
        reg_en[EN_R] = 1'b1;
        x_sel        = ir[4];
        y_sel        = ir[3];
      end else if (ir[7:4] == OP_JMP) begin
        jump_taken = 1'b1;
      end else begin
        jump_taken = ~r_eq_0;
      end
    end
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Program sequencer: pc, 2-stage fetch/execute pipeline and run/halt FSM.
module instruction_sequencer
  import seq_pkg::*;
(
  input  logic                    clk,
  input  logic                    sync_reset,
  instruction_sequencer_if.master bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            ir_valid_q, ir_valid_d;
  logic            jump_taken;
  logic [PC_W-1:0] jump_target;

  instruction_decoder u_dec (
    .ir          (ir_q),
    .ir_valid    (ir_valid_q),
    .r_eq_0      (bus.r_eq_0),
    .source_sel  (bus.source_sel),
    .reg_en      (bus.reg_en),
    .i_sel       (bus.i_sel),
    .x_sel       (bus.x_sel),
    .y_sel       (bus.y_sel),
    .nibble_ir   (bus.nibble_ir),
    .jump_taken  (jump_taken),
    .jump_target (jump_target)
  );

  // State register
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state: DRAIN lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.run) state_d = ST_RUN;
      ST_RUN:   if (!bus.run) state_d = ST_DRAIN;
      ST_DRAIN: state_d = bus.run ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Pipeline update: taken jump beats fetch; leaving RUN flushes ir
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    if (state_q == ST_RUN) begin
      if (jump_taken) begin
        pc_d       = jump_target;
        ir_d       = NOP_IR;
        ir_valid_d = 1'b0;
      end else if (bus.run) begin
        pc_d       = pc_q + PC_W'(1);
        ir_d       = bus.pm_data;
        ir_valid_d = 1'b1;
      end else begin
        ir_d       = NOP_IR;
        ir_valid_d = 1'b0;
      end
    end else begin
      ir_d       = NOP_IR;
      ir_valid_d = 1'b0;
    end
  end

  // pc / ir registers
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      pc_q       <= '0;
      ir_q       <= NOP_IR;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign bus.pm_addr  = pc_q;
  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.state    = 2'(state_q);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed scoreboard bench for instruction_sequencer.
module tb_instruction_sequencer;

  logic clk = 1'b0;
  logic sync_reset;
  logic [7:0] rom [256];

  int checks   = 0;
  int failures = 0;
  int n_step   = 0;

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ir;
    logic       v;
    logic [1:0] st;
    logic [8:0] en;
    logic [3:0] src;
    logic       isel;
    logic       xs;
    logic       ys;
    logic [3:0] nib;
  } exp_t;

  exp_t q[$];

  // reference model state
  logic [7:0] m_pc;
  logic [7:0] m_ir;
  logic       m_v;
  logic [1:0] m_st;

  instruction_sequencer_if bus ();

  instruction_sequencer dut (
    .clk        (clk),
    .sync_reset (sync_reset),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  assign bus.pm_data = rom[bus.pm_addr];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] en_of(input logic [2:0] d);
    logic [8:0] one;
    one = 9'd1;
    if (d == 3'd4) return 9'h100;
    return one << d;
  endfunction

  // Expected visible outputs from the model state
  function automatic exp_t snap();
    exp_t e;
    e = '{default: '0};
    e.pc = m_pc;
    e.ir = m_ir;
    e.v  = m_v;
    e.st = m_st;
    if (m_v) begin
      e.nib = m_ir[3:0];
      casez (m_ir)
        8'b0???????: begin
          e.src = 4'd8;
          e.en  = en_of(m_ir[6:4]);
        end
        8'b10??????: begin
          e.en = en_of(m_ir[5:3]);
          if (m_ir[5:3] == m_ir[2:0] && m_ir[5:3] != 3'd6) e.src = 4'd9;
          else e.src = {1'b0, m_ir[2:0]};
          e.isel = (m_ir[5:0] == 6'o66);
        end
        8'b110?????: begin
          e.en = 9'h010;
          e.xs = m_ir[4];
          e.ys = m_ir[3];
        end
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    chk({tag, ".pc"},   16'(bus.pc),         16'(e.pc));
    chk({tag, ".addr"}, 16'(bus.pm_addr),    16'(e.pc));
    chk({tag, ".ir"},   16'(bus.ir),         16'(e.ir));
    chk({tag, ".v"},    16'(bus.ir_valid),   16'(e.v));
    chk({tag, ".st"},   16'(bus.state),      16'(e.st));
    chk({tag, ".en"},   16'(bus.reg_en),     16'(e.en));
    chk({tag, ".src"},  16'(bus.source_sel), 16'(e.src));
    chk({tag, ".isel"}, 16'(bus.i_sel),      16'(e.isel));
    chk({tag, ".xy"},   16'({bus.x_sel, bus.y_sel}), 16'({e.xs, e.ys}));
    chk({tag, ".nib"},  16'(bus.nibble_ir),  16'(e.nib));
  endtask

  // Predict the next edge, queue it, clock, then pop and compare
  task automatic step();
    logic tk;
    exp_t e;
    tk = m_v && (m_ir[7:4] == 4'hE || (m_ir[7:4] == 4'hF && !bus.r_eq_0));
    case (m_st)
      2'b00: m_st = bus.run ? 2'b01 : 2'b00;
      2'b01: begin
        if (tk) begin
          m_pc = {m_ir[3:0], 4'h0};
          m_ir = 8'hC8;
          m_v  = 1'b0;
        end else if (bus.run) begin
          m_ir = rom[m_pc];
          m_v  = 1'b1;
          m_pc = m_pc + 8'd1;
        end else begin
          m_ir = 8'hC8;
          m_v  = 1'b0;
        end
        if (!bus.run) m_st = 2'b10;
      end
      default: begin
        m_st = bus.run ? 2'b01 : 2'b00;
        m_ir = 8'hC8;
        m_v  = 1'b0;
      end
    endcase
    q.push_back(snap());
    @(posedge clk);
    #1;
    n_step++;
    e = q.pop_front();
    compare($sformatf("s%0d", n_step), e);
  endtask

  // Async reset pulse: checked before any clock edge
  task automatic do_reset();
    sync_reset = 1'b1;
    #2;
    chk("rst.pc",  16'(bus.pc),       16'h00);
    chk("rst.en",  16'(bus.reg_en),   16'h000);
    chk("rst.ir",  16'(bus.ir),       16'hC8);
    chk("rst.v",   16'(bus.ir_valid), 16'h0);
    chk("rst.st",  16'(bus.state),    16'h0);
    @(posedge clk);
    #1;
    sync_reset = 1'b0;
    m_pc = 8'h00;
    m_ir = 8'hC8;
    m_v  = 1'b0;
    m_st = 2'b00;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) rom[i] = 8'hC8;
  endtask

  initial begin
    sync_reset = 1'b1;
    bus.run    = 1'b0;
    bus.r_eq_0 = 1'b1;
    fill_nop();

    // LOAD x0,5 after reset with run high
    rom[0] = 8'h05;
    do_reset();
    bus.run = 1'b1;
    step();
    step();
    chk("load.ir",  16'(bus.ir),         16'h05);
    chk("load.pc",  16'(bus.pc),         16'h01);
    chk("load.en",  16'(bus.reg_en),     16'h001);
    chk("load.src", 16'(bus.source_sel), 16'h8);
    chk("load.nib", 16'(bus.nibble_ir),  16'h5);
    do_reset();

    // JMP 30 with a one-cycle bubble
    fill_nop();
    rom[8'h00] = 8'hE3;
    rom[8'h01] = 8'h0F;
    rom[8'h30] = 8'h18;
    do_reset();
    step();
    step();
    chk("jmp.ir", 16'(bus.ir), 16'hE3);
    step();
    chk("jmp.pc", 16'(bus.pc),       16'h30);
    chk("jmp.v",  16'(bus.ir_valid), 16'h0);
    step();
    chk("jmp.tgt_ir", 16'(bus.ir),     16'h18);
    chk("jmp.tgt_en", 16'(bus.reg_en), 16'h002);

    // JNZ not taken then taken
    fill_nop();
    rom[8'h00] = 8'hF2;
    rom[8'h01] = 8'hF2;
    rom[8'h20] = 8'h05;
    do_reset();
    step();
    step();
    bus.r_eq_0 = 1'b1;
    step();
    chk("jnz_nt.pc", 16'(bus.pc), 16'h02);
    bus.r_eq_0 = 1'b0;
    step();
    chk("jnz_t.pc", 16'(bus.pc),       16'h20);
    chk("jnz_t.v",  16'(bus.ir_valid), 16'h0);
    step();
    chk("jnz_t.ir", 16'(bus.ir), 16'h05);
    bus.r_eq_0 = 1'b1;

    // MOVE and ALU decode
    fill_nop();
    rom[0] = 8'hB6;
    rom[1] = 8'h89;
    rom[2] = 8'hA1;
    rom[3] = 8'hD1;
    do_reset();
    step();
    step();
    chk("mv_ii.en",   16'(bus.reg_en), 16'h040);
    chk("mv_ii.isel", 16'(bus.i_sel),  16'h1);
    step();
    chk("mv_x1.src", 16'(bus.source_sel), 16'h9);
    chk("mv_x1.en",  16'(bus.reg_en),     16'h002);
    step();
    chk("mv_o.src", 16'(bus.source_sel), 16'h1);
    chk("mv_o.en",  16'(bus.reg_en),     16'h100);
    step();
    chk("alu.en",  16'(bus.reg_en),    16'h010);
    chk("alu.xy",  16'({bus.x_sel, bus.y_sel}), 16'b10);
    chk("alu.nib", 16'(bus.nibble_ir), 16'h1);

    // pc wrap FF -> 00
    fill_nop();
    rom[0] = 8'hEF;
    do_reset();
    step();
    step();
    step();
    repeat (15) step();
    chk("wrap.ff", 16'(bus.pc), 16'hFF);
    step();
    chk("wrap.00", 16'(bus.pc), 16'h00);

    // Drain with ir=03 at pc=05, then resume
    fill_nop();
    rom[4] = 8'h03;
    rom[5] = 8'h07;
    do_reset();
    step();
    repeat (5) step();
    chk("drn.ir", 16'(bus.ir),     16'h03);
    chk("drn.pc", 16'(bus.pc),     16'h05);
    chk("drn.en", 16'(bus.reg_en), 16'h001);
    bus.run = 1'b0;
    step();
    chk("drn.st", 16'(bus.state),    16'h2);
    chk("drn.v",  16'(bus.ir_valid), 16'h0);
    chk("drn.pc2", 16'(bus.pc),      16'h05);
    step();
    chk("idle.st", 16'(bus.state), 16'h0);
    step();
    chk("idle.pc", 16'(bus.pc), 16'h05);
    bus.run = 1'b1;
    step();
    step();
    chk("resume.ir", 16'(bus.ir), 16'h07);
    chk("resume.pc", 16'(bus.pc), 16'h06);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
